substitute: RTL and testbench
=============================

SUBSTITUTE -- requirements
Module: substitute

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  start request, sampled on the clk rising edge.
REQ-005 data_in  input  132  bits [131:128] header, bits [127:0] AES state.
REQ-006 data_out  output  132  registered result: header plus SubBytes-transformed state.
REQ-007 busy  output  1  high while a transform is in progress.
REQ-008 done  output  1  one-cycle pulse coinciding with the data_out update.
REQ-009 Parameter VALID_HDR, default 4'h7: the header value marking a block as valid.

Function
REQ-010 FSM states SHALL be IDLE, SUB_LO, SUB_HI and WRITE; the reset state is IDLE.
REQ-011 IDLE with load=1: capture data_in into an internal 132-bit working register; next state SUB_LO.
REQ-012 SUB_LO: replace bits [63:0] of the working register byte-wise with the FIPS-197 forward S-box (8 lookups); next state SUB_HI.
REQ-013 SUB_HI: replace bits [127:64] byte-wise with the forward S-box (same 8 lookups, muxed); next state WRITE.
REQ-014 WRITE: load data_out from the working register, pulse done=1 for exactly that cycle, return to IDLE.
REQ-015 Latency: data_out and done SHALL change on the 3rd rising edge after the edge that samples load=1.
REQ-016 The header SHALL pass through unchanged; only bits [127:0] are substituted.
REQ-017 busy SHALL be 1 in SUB_LO, SUB_HI and WRITE, and 0 in IDLE.
REQ-018 load in any non-IDLE state SHALL be ignored: no recapture and no restart.
REQ-019 load=1 in WRITE SHALL be ignored; a new capture requires load=1 sampled in IDLE, so back-to-back blocks need at least 4 cycles.
REQ-020 data_out SHALL hold its last value between completions, independent of data_in and load.
REQ-021 S-box lookups SHALL be combinational ROM tables; no S-box pipelining.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, data_out=0, busy=0, done=0, and clear the working register, including mid-transform.
REQ-023 A transform interrupted by reset SHALL never produce a done pulse or a data_out update.
REQ-024 The first load SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro SUB_HEADER_CHECK_EN SHALL be the only compile-time option.
REQ-026 With SUB_HEADER_CHECK_EN defined, a captured header not equal to VALID_HDR SHALL still run the full 3-cycle sequence, but WRITE loads data_out with all zeros; done still pulses.
REQ-027 With SUB_HEADER_CHECK_EN undefined, the header SHALL be ignored, and every block is substituted and written with its header passed through.

Verification
REQ-028 Reset, then load with data_in=7_00112233445566778899AABBCCDDEEFF -> 3 edges later data_out=7_638293C31BFC33F5C4EEACEA4BC12816 and done=1 for one cycle; busy was 1 for 3 cycles.
REQ-029 Same block, then wait 5 extra cycles with data_in changed to 0 -> data_out still 7_638293C31BFC33F5C4EEACEA4BC12816.
REQ-030 With SUB_HEADER_CHECK_EN defined, load 0_00112233445566778899AABBCCDDEEFF -> data_out=0 and done pulses at latency 3; without the macro -> data_out=0_638293C31BFC33F5C4EEACEA4BC12816.
REQ-031 Load block A, then hold load=1 with data_in=block B during SUB_LO, SUB_HI and WRITE -> output is A's result only; B is captured on the next IDLE cycle and its result follows 3 edges later.
REQ-032 Load a valid block, then assert rst during SUB_HI -> data_out=0, busy=0, no done pulse; a fresh load after reset yields the correct result at latency 3.
REQ-033 Load all-FF state with header 7 -> data_out=7_16161616161616161616161616161616; load all-00 state -> 7_63636363636363636363636363636363.

Source files
------------

// File: rtl/substitute.sv
// substitute: AES SubBytes on a 132-bit header+state block, two 64-bit halves over consecutive cycles.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   load      start request, accepted only when idle
//   data_in   [131:128] header, [127:0] AES state
//   data_out  registered result, holds between completions
//   busy      high while a block is in flight
//   done      one-cycle pulse coinciding with the data_out update
// Parameter VALID_HDR: header value marking a block as valid.
// Macro SUB_HEADER_CHECK_EN: when defined, blocks with a header other than VALID_HDR write all zeros.
module substitute #(
    parameter logic [3:0] VALID_HDR = 4'h7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [131:0] data_in,
    output logic [131:0] data_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, SUB_LO, SUB_HI, WRITE} state_t;

`ifdef SUB_HEADER_CHECK_EN
    localparam bit CHECK_HDR = 1'b1;
`else
    localparam bit CHECK_HDR = 1'b0;
`endif

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t        state, state_nxt;
    logic [131:0]  work, wr_data;
    logic [63:0]   sub_in, sub_out;

    // One bank of 8 lookups shared by both halves; ~x == 255-x selects entry x.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_sbox
            assign sub_out[i*8 +: 8] = SBOX[{~sub_in[i*8 +: 8], 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        state_nxt = (state == IDLE)   ? (load ? SUB_LO : IDLE) :
                    (state == SUB_LO) ? SUB_HI :
                    (state == SUB_HI) ? WRITE  : IDLE;
        sub_in    = (state == SUB_LO) ? work[63:0] : work[127:64];
        wr_data   = (!CHECK_HDR || work[131:128] == VALID_HDR) ? work : '0;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == WRITE);
            if (state == IDLE && load) work <= data_in;
            if (state == SUB_LO) work[63:0] <= sub_out;
            if (state == SUB_HI) work[127:64] <= sub_out;
            if (state == WRITE) data_out <= wr_data;
        end
    end
endmodule

// File: tb/tb_substitute.sv
// tb_substitute: randomized check of substitute against an S-box computed from GF(2^8) arithmetic.
module tb_substitute;
    logic         tb_clk = 1'b0;
    logic         rst;
    logic         load;
    logic [131:0] data_in;
    logic [131:0] data_out;
    logic         busy;
    logic         done;

    int n_chk = 0;
    int n_fail = 0;

    logic [131:0] m_out, m_res;
    logic         m_done;
    int           m_rem;

    int           pin_mode = 0;
    logic [131:0] pin_val = '0;

    localparam logic [131:0] BLK_A   = 132'h7_00112233445566778899AABBCCDDEEFF;
    localparam logic [131:0] RES_A   = 132'h7_638293C31BFC33F5C4EEACEA4BC12816;
    localparam logic [131:0] BLK_H0  = 132'h0_00112233445566778899AABBCCDDEEFF;
    localparam logic [131:0] BLK_FF  = {4'h7, {16{8'hFF}}};
    localparam logic [131:0] RES_FF  = 132'h7_16161616161616161616161616161616;
    localparam logic [131:0] BLK_00  = {4'h7, 128'h0};
    localparam logic [131:0] RES_00  = 132'h7_63636363636363636363636363636363;

    substitute dut (
        .clk(tb_clk), .rst(rst), .load(load), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 tb_clk = ~tb_clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Multiplicative inverse as x^254 followed by the AES affine map.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] p = 8'h01;
        for (int k = 0; k < 254; k++) p = gmul(p, x);
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [131:0] expect_of(input logic [131:0] d);
        logic [131:0] r;
        r[131:128] = d[131:128];
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = sb(d[k*8 +: 8]);
`ifdef SUB_HEADER_CHECK_EN
        if (d[131:128] != 4'h7) r = '0;
`endif
        return r;
    endfunction

    // Reference: an accepted block completes exactly three edges after acceptance.
    always @(posedge tb_clk or posedge rst) begin
        if (rst) begin
            m_out = '0; m_res = '0; m_done = 1'b0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
            if (m_rem == 0) m_out = m_res;
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_res = expect_of(data_in);
                m_rem = 3;
            end
        end
    end

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        chk("sbox_00", {124'd0, sb(8'h00)}, 132'h63);
        chk("sbox_ff", {124'd0, sb(8'hFF)}, 132'h16);
        chk("sbox_53", {124'd0, sb(8'h53)}, 132'hED);
        forever begin
            @(negedge tb_clk);
            chk("data_out", data_out, m_out);
            chk("busy", {131'd0, busy}, {131'd0, m_rem > 0});
            chk("done", {131'd0, done}, {131'd0, m_done});
            if (pin_mode == 1 && done) chk("pin_done", data_out, pin_val);
            if (pin_mode == 2) chk("pin_hold", data_out, pin_val);
        end
    end

    task automatic step;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic run_block(input logic [131:0] d, input logic [131:0] exp);
        pin_mode = 1;
        pin_val = exp;
        data_in = d;
        load = 1'b1;
        step;
        load = 1'b0;
        repeat (4) step;
        pin_mode = 0;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        data_in = '0;
        repeat (3) step;
        rst = 1'b0;
        run_block(BLK_A, RES_A);
        data_in = '0;
        pin_mode = 2;
        pin_val = RES_A;
        repeat (5) step;
        pin_mode = 0;
`ifdef SUB_HEADER_CHECK_EN
        run_block(BLK_H0, '0);
`else
        run_block(BLK_H0, {4'h0, RES_A[127:0]});
`endif
        data_in = BLK_A;
        load = 1'b1;
        step;
        data_in = BLK_FF;
        repeat (4) step;
        load = 1'b0;
        repeat (5) step;
        data_in = BLK_00;
        load = 1'b1;
        step;
        load = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        run_block(BLK_A, RES_A);
        run_block(BLK_FF, RES_FF);
        run_block(BLK_00, RES_00);
        repeat (400) begin
            rst = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 2) == 0);
            data_in[127:0] = {$urandom, $urandom, $urandom, $urandom};
            data_in[131:128] = ($urandom_range(0, 3) != 0) ? 4'h7 : 4'($urandom);
            step;
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (6) step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
